traffic_phase_scheduler: RTL and testbench

- Actuated phase scheduler for a 4-way intersection: one NS approach pair and one EW approach pair.
- Arbitrates vehicle-detector demand, latched pedestrian requests and an emergency pre-emption request into a timed green / yellow / all-red sequence.
- Drives the NS and EW lamp buses and the walk signals.
- Timing runs on a 1-second tick divided down from clk.

---
 rtl/traffic_phase_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-phase intersection scheduler with pedestrian walk and emergency pre-emption.
// Timing advances on a 1 s tick divided from clk; all outputs are registered.
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 50,
  parameter int unsigned YELLOW_T  = 6,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       car_ns_i,
  input  logic       car_ew_i,
  input  logic       ped_ns_req_i,
  input  logic       ped_ew_req_i,
  input  logic       emerg_req_i,
  input  logic       emerg_dir_i,
  output logic [2:0] north_south_o,
  output logic [2:0] east_west_o,
  output logic       walk_ns_o,
  output logic       walk_ew_o,
  output logic       ped_ns_ack_o,
  output logic       ped_ew_ack_o,
  output logic [2:0] phase_o
);

  localparam logic [2:0] StInit = 3'b000;
  localparam logic [2:0] StNsG  = 3'b001;
  localparam logic [2:0] StNsY  = 3'b010;
  localparam logic [2:0] StAr1  = 3'b011;
  localparam logic [2:0] StEwG  = 3'b100;
  localparam logic [2:0] StEwY  = 3'b101;
  localparam logic [2:0] StAr2  = 3'b110;
  localparam logic [2:0] StPre  = 3'b111;

  localparam logic [2:0] LGreen  = 3'b100;
  localparam logic [2:0] LYellow = 3'b010;
  localparam logic [2:0] LRed    = 3'b001;

  localparam int unsigned TMaxA = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int unsigned TMax  = (TMaxA > ALLRED_T) ? TMaxA : ALLRED_T;
  localparam int unsigned TW    = $clog2(TMax + 1);
  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PLast   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TCap    = TW'(TMax);
  localparam logic [TW-1:0] TGMin   = TW'(GREEN_MIN);
  localparam logic [TW-1:0] TGMax   = TW'(GREEN_MAX);
  localparam logic [TW-1:0] TYel    = TW'(YELLOW_T);
  localparam logic [TW-1:0] TAllRed = TW'(ALLRED_T);
  localparam logic [TW-1:0] TWalk   = TW'(WALK_T);

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] timer_q, timer_d, t_inc;
  logic [2:0]    state_q, state_d;
  logic          pre_dir_q, pre_dir_d;
  logic          pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic          walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  logic          ack_ns_q, ack_ns_d, ack_ew_q, ack_ew_d;
  logic [2:0]    ns_q, ns_d, ew_q, ew_d;
  logic          tick, dem_ns, dem_ew;

  always_comb begin
    tick    = en_i && (presc_q == PLast);
    presc_d = presc_q;
    if (en_i) presc_d = tick ? '0 : presc_q + 1'b1;
    t_inc   = (timer_q == TCap) ? timer_q : timer_q + 1'b1;
    dem_ns  = car_ns_i | pend_ns_q;
    dem_ew  = car_ew_i | pend_ew_q;

    // Interval ends use the post-tick count, so a state lasts exactly its tick budget.
    state_d   = state_q;
    pre_dir_d = pre_dir_q;
    if (en_i) begin
      case (state_q)
        StInit, StAr2: begin
          if (tick && t_inc >= TAllRed) begin
            if (emerg_req_i) begin
              state_d   = StPre;
              pre_dir_d = emerg_dir_i;
            end else begin
              state_d = StNsG;
            end
          end
        end
        StAr1: begin
          if (tick && t_inc >= TAllRed) begin
            if (emerg_req_i) begin
              state_d   = StPre;
              pre_dir_d = emerg_dir_i;
            end else begin
              state_d = StEwG;
            end
          end
        end
        StNsG: begin
          if (emerg_req_i) begin
            if (emerg_dir_i) begin
              state_d = StNsY;
            end else begin
              state_d   = StPre;
              pre_dir_d = 1'b0;
            end
          end else if (tick && dem_ew &&
                       ((t_inc >= TGMin && !car_ns_i) || t_inc >= TGMax)) begin
            state_d = StNsY;
          end
        end
        StEwG: begin
          if (emerg_req_i) begin
            if (!emerg_dir_i) begin
              state_d = StEwY;
            end else begin
              state_d   = StPre;
              pre_dir_d = 1'b1;
            end
          end else if (tick && dem_ns &&
                       ((t_inc >= TGMin && !car_ew_i) || t_inc >= TGMax)) begin
            state_d = StEwY;
          end
        end
        StNsY: if (tick && t_inc >= TYel) state_d = StAr1;
        StEwY: if (tick && t_inc >= TYel) state_d = StAr2;
        StPre: if (tick && !emerg_req_i) state_d = pre_dir_q ? StEwY : StNsY;
        default: state_d = StInit;
      endcase
    end

    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
    else if (tick)          timer_d = t_inc;

    // Walk is armed only by a request pending at green entry, then runs out on the timer.
    walk_ns_d = (state_d == StNsG) && ((state_q != StNsG) ? pend_ns_q : walk_ns_q) &&
                (timer_d < TWalk);
    walk_ew_d = (state_d == StEwG) && ((state_q != StEwG) ? pend_ew_q : walk_ew_q) &&
                (timer_d < TWalk);
    ack_ns_d  = walk_ns_d && !walk_ns_q;
    ack_ew_d  = walk_ew_d && !walk_ew_q;
    pend_ns_d = ack_ns_d ? 1'b0 : (pend_ns_q | ped_ns_req_i);
    pend_ew_d = ack_ew_d ? 1'b0 : (pend_ew_q | ped_ew_req_i);

    ns_d = LRed;
    ew_d = LRed;
    case (state_d)
      StNsG:   ns_d = LGreen;
      StNsY:   ns_d = LYellow;
      StEwG:   ew_d = LGreen;
      StEwY:   ew_d = LYellow;
      StPre: begin
        if (pre_dir_d) ew_d = LGreen;
        else           ns_d = LGreen;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      timer_q   <= '0;
      state_q   <= StInit;
      pre_dir_q <= 1'b0;
      pend_ns_q <= 1'b0;
      pend_ew_q <= 1'b0;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
      ack_ns_q  <= 1'b0;
      ack_ew_q  <= 1'b0;
      ns_q      <= LRed;
      ew_q      <= LRed;
    end else begin
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
      pre_dir_q <= pre_dir_d;
      pend_ns_q <= pend_ns_d;
      pend_ew_q <= pend_ew_d;
      walk_ns_q <= walk_ns_d;
      walk_ew_q <= walk_ew_d;
      ack_ns_q  <= ack_ns_d;
      ack_ew_q  <= ack_ew_d;
      ns_q      <= ns_d;
      ew_q      <= ew_d;
    end
  end

  assign north_south_o = ns_q;
  assign east_west_o   = ew_q;
  assign walk_ns_o     = walk_ns_q;
  assign walk_ew_o     = walk_ew_q;
  assign ped_ns_ack_o  = ack_ns_q;
  assign ped_ew_ack_o  = ack_ew_q;
  assign phase_o       = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: each output change is matched against a queued vector and its spacing
// in clock edges from the previous change.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0;
  logic       car_ns = 1'b0, car_ew = 1'b0, ped_ns = 1'b0, ped_ew = 1'b0;
  logic       emerg = 1'b0, edir = 1'b0;
  logic [2:0] ns, ew, phase;
  logic       walk_ns, walk_ew, ack_ns, ack_ew;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .TICK_DIV (4),
    .GREEN_MIN(3),
    .GREEN_MAX(6),
    .YELLOW_T (2),
    .ALLRED_T (1),
    .WALK_T   (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .car_ns_i     (car_ns),
    .car_ew_i     (car_ew),
    .ped_ns_req_i (ped_ns),
    .ped_ew_req_i (ped_ew),
    .emerg_req_i  (emerg),
    .emerg_dir_i  (edir),
    .north_south_o(ns),
    .east_west_o  (ew),
    .walk_ns_o    (walk_ns),
    .walk_ew_o    (walk_ew),
    .ped_ns_ack_o (ack_ns),
    .ped_ew_ack_o (ack_ew),
    .phase_o      (phase)
  );

  localparam logic [2:0] R = 3'b001, Y = 3'b010, G = 3'b100;

  typedef struct {
    logic [12:0] vec;
    int          dt;
  } exp_t;

  exp_t q[$];
  int   ecnt    = -3;
  int   n_check = 0;
  int   n_pass  = 0;
  int   ev_idx  = 0;
  bit   mon_on  = 1'b0;

  // Vector layout: phase, NS lamp, EW lamp, {walk_ns, walk_ew, ack_ns, ack_ew}.
  function automatic logic [12:0] mk(input logic [2:0] ph, input logic [2:0] l_ns,
                                     input logic [2:0] l_ew, input logic [3:0] w);
    return {ph, l_ns, l_ew, w};
  endfunction

  task automatic push(input logic [12:0] v, input int dt);
    exp_t e;
    e.vec = v;
    e.dt  = dt;
    q.push_back(e);
  endtask

  task automatic at_edge(input int n);
    while (ecnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    ecnt = ecnt + 1;
  end

  initial begin : monitor
    logic [12:0] cur, prev;
    int          since;
    bit          first;
    exp_t        e;
    first = 1'b1;
    since = 0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cur   = {phase, ns, ew, walk_ns, walk_ew, ack_ns, ack_ew};
        since = since + 1;
        if (first || cur !== prev) begin
          if (first) since = 0;
          first = 1'b0;
          if (q.size() == 0) begin
            n_check = n_check + 1;
            $display("FAIL unexpected_change edge=%0d got=%b", ecnt, cur);
          end else begin
            e = q.pop_front();
            n_check = n_check + 1;
            if (cur === e.vec) n_pass = n_pass + 1;
            else $display("FAIL event%0d_vector edge=%0d got=%b want=%b", ev_idx, ecnt, cur,
                          e.vec);
            n_check = n_check + 1;
            if (since == e.dt) n_pass = n_pass + 1;
            else $display("FAIL event%0d_spacing edge=%0d got=%0d want=%0d", ev_idx, ecnt,
                          since, e.dt);
          end
          ev_idx = ev_idx + 1;
          prev   = cur;
          since  = 0;
        end
      end
    end
  end

  initial begin
    // Reset, then idle: INIT lasts one tick, NS green rests with no opposing demand.
    at_edge(0);
    rst = 1'b0; en = 1'b1; mon_on = 1'b1;
    push(mk(3'd0, R, R, 4'b0000), 0);
    push(mk(3'd1, G, R, 4'b0000), 4);

    at_edge(204);
    car_ew = 1'b1;
    push(mk(3'd2, Y, R, 4'b0000), 204);
    push(mk(3'd3, R, R, 4'b0000), 8);
    push(mk(3'd4, R, G, 4'b0000), 4);

    at_edge(220);
    car_ns = 1'b1; car_ew = 1'b0;
    push(mk(3'd5, R, Y, 4'b0000), 12);
    push(mk(3'd6, R, R, 4'b0000), 8);
    push(mk(3'd1, G, R, 4'b0000), 4);

    // Both approaches busy: NS maxes out.
    at_edge(244);
    car_ew = 1'b1;
    push(mk(3'd2, Y, R, 4'b0000), 24);
    push(mk(3'd3, R, R, 4'b0000), 8);
    push(mk(3'd4, R, G, 4'b0000), 4);

    at_edge(280);
    car_ew = 1'b0;
    push(mk(3'd5, R, Y, 4'b0000), 12);
    push(mk(3'd6, R, R, 4'b0000), 8);
    push(mk(3'd1, G, R, 4'b0000), 4);

    at_edge(304);
    car_ns = 1'b0;

    // EW pedestrian pulse is the only demand.
    at_edge(310);
    ped_ew = 1'b1;
    push(mk(3'd2, Y, R, 4'b0000), 12);
    push(mk(3'd3, R, R, 4'b0000), 8);
    push(mk(3'd4, R, G, 4'b0101), 4);
    push(mk(3'd4, R, G, 4'b0100), 1);
    push(mk(3'd4, R, G, 4'b0000), 7);
    at_edge(311);
    ped_ew = 1'b0;

    at_edge(340);
    ped_ns = 1'b1;
    push(mk(3'd5, R, Y, 4'b0000), 8);
    push(mk(3'd6, R, R, 4'b0000), 8);
    push(mk(3'd1, G, R, 4'b1010), 4);
    push(mk(3'd1, G, R, 4'b1000), 1);
    push(mk(3'd1, G, R, 4'b0000), 7);
    at_edge(341);
    ped_ns = 1'b0;

    // Pre-emption toward EW from NS green; direction changes inside PRE are ignored.
    at_edge(366);
    emerg = 1'b1; edir = 1'b1;
    push(mk(3'd2, Y, R, 4'b0000), 3);
    push(mk(3'd3, R, R, 4'b0000), 5);
    push(mk(3'd7, R, G, 4'b0000), 4);
    at_edge(390);
    edir = 1'b0;
    at_edge(401);
    emerg = 1'b0;
    push(mk(3'd5, R, Y, 4'b0000), 28);
    push(mk(3'd6, R, R, 4'b0000), 8);
    push(mk(3'd1, G, R, 4'b0000), 4);

    at_edge(416);
    car_ew = 1'b1;
    push(mk(3'd2, Y, R, 4'b0000), 12);
    at_edge(428);
    car_ew = 1'b0;

    // Freeze mid-yellow for 50 edges; a pedestrian press while frozen still latches.
    at_edge(430);
    en = 1'b0;
    push(mk(3'd3, R, R, 4'b0000), 58);
    push(mk(3'd4, R, G, 4'b0000), 4);
    push(mk(3'd5, R, Y, 4'b0000), 12);
    push(mk(3'd6, R, R, 4'b0000), 8);
    push(mk(3'd1, G, R, 4'b1010), 4);
    push(mk(3'd1, G, R, 4'b1000), 1);
    push(mk(3'd1, G, R, 4'b0000), 7);
    at_edge(440);
    ped_ns = 1'b1;
    at_edge(441);
    ped_ns = 1'b0;
    at_edge(480);
    en = 1'b1;

    at_edge(522);
    car_ew = 1'b1;
    push(mk(3'd2, Y, R, 4'b0000), 4);
    push(mk(3'd3, R, R, 4'b0000), 8);
    push(mk(3'd4, R, G, 4'b0000), 4);

    // Reset in the middle of EW green.
    at_edge(540);
    rst = 1'b1;
    push(mk(3'd0, R, R, 4'b0000), 3);
    at_edge(541);
    rst = 1'b0; car_ew = 1'b0;
    push(mk(3'd1, G, R, 4'b0000), 4);

    at_edge(560);
    n_check = n_check + 1;
    if (q.size() == 0) n_pass = n_pass + 1;
    else $display("FAIL pending_events got=%0d want=0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
